// File: rtl/soc_pkg.sv
// Shared SoC definitions for the data-memory responder: default window,
// bus word/byte-enable types and the response FSM encoding.
package soc_pkg;

    localparam logic [31:0] DMEM_BASE = 32'h1000_0000;
    localparam int unsigned DMEM_SIZE = 4096;

    typedef logic [3:0]  be_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_e;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data memory bus (req/gnt/rvalid) between the core (master) and a responder (slave).
interface data_sram_responder_if;
    import soc_pkg::*;

    logic  data_req_i;
    logic  data_gnt_o;
    logic  data_rvalid_o;
    logic  data_we_i;
    be_t   data_be_i;
    word_t data_addr_i;
    word_t data_wdata_i;
    word_t data_rdata_o;
    logic  data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/sram_1rw_be.sv
// Single-port synchronous word array with per-byte write enables and a
// registered read port; contents and read register are never reset.
module sram_1rw_be
    import soc_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  be_t               be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  word_t             wdata_i,
    output word_t             rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    // Read data is held until the next read access, not just for one cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-memory responder: serves loads/stores from an on-chip SRAM window with
// configurable response latency; out-of-window accesses get an error response.
module data_sram_responder
    import soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DMEM_BASE,
    parameter int unsigned SIZE_BYTES = DMEM_SIZE,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave bus
);

    localparam int unsigned DEPTH    = SIZE_BYTES / 4;
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BASE_W   = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_W  = BASE_W + 33'(SIZE_BYTES);
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

    resp_state_e      state_q;
    logic [1:0]       cnt_q;
    logic             rvalid_q;
    logic             err_q;
    logic             rd_q;
    logic             err_pend_q;
    logic             rd_pend_q;

    logic             ready;
    logic             gnt;
    logic             hit;
    logic             rd_hit;
    logic [32:0]      addr_w;
    logic [IDX_W-1:0] word_idx;
    word_t            sram_rdata;

    // Window check in 33 bits so addresses near 0xFFFF_FFFF cannot wrap into range.
    assign addr_w   = {1'b0, bus.data_addr_i};
    assign hit      = (addr_w >= BASE_W) && (addr_w < LIMIT_W);
    assign rd_hit   = hit && !bus.data_we_i;
    assign word_idx = IDX_W'((bus.data_addr_i - BASE_ADDR) >> 2);

    assign ready = (state_q == IDLE) || rvalid_q;
    assign gnt   = bus.data_req_i && ready && rst;

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_err_o    = err_q;
    assign bus.data_rdata_o  = rd_q ? sram_rdata : '0;

    sram_1rw_be #(
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_sram (
        .clk     (clk),
        .en_i    (gnt && hit),
        .we_i    (bus.data_we_i),
        .be_i    (bus.data_be_i),
        .addr_i  (word_idx),
        .wdata_i (bus.data_wdata_i),
        .rdata_o (sram_rdata)
    );

    // rvalid/err/rd are one-cycle pulses raised only on entry to RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            err_pend_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            unique case (state_q)
                IDLE, RESP: begin
                    if (gnt) begin
                        if (LATENCY > 1) begin
                            state_q    <= WAIT;
                            cnt_q      <= CNT_INIT;
                            err_pend_q <= !hit;
                            rd_pend_q  <= rd_hit;
                        end else begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            err_q    <= !hit;
                            rd_q     <= rd_hit;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge that enters RESP.
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= err_pend_q;
                        rd_q     <= rd_pend_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder end of the core's data memory interface (req/gnt/rvalid/we/be/addr/wdata/rdata/err). It sits beside the processor block and serves data loads and stores from an on-chip byte-writable SRAM window. The response latency is configurable. Accesses outside the window return an error response.

Parameters:
BASE_ADDR, 32'h1000_0000, byte address of first word of the window (word aligned)
SIZE_BYTES, 4096, window size in bytes; power of two, >= 4
LATENCY, 1, cycles from grant edge to rvalid; legal range 1..4

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
data_req_i  input  1  request valid from initiator
data_gnt_o  output  1  request accepted this cycle
data_rvalid_o  output  1  response valid
data_we_i  input  1  1 = write, 0 = read
data_be_i  input  4  byte enables; bit n covers wdata[8n+7:8n]
data_addr_i  input  32  byte address; bits [1:0] ignored
data_wdata_i  input  32  write data
data_rdata_o  output  32  read data, valid with rvalid
data_err_o  output  1  access error, valid with rvalid

Behaviour:
- Reset (rst low): data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, FSM=IDLE, counter=0.
- Reset while busy: any pending response is discarded; no rvalid for it after release. SRAM contents are never cleared by reset. A write granted before reset is already committed.
- ready = (state==IDLE) || data_rvalid_o.
- data_gnt_o = data_req_i && ready && rst. This is combinational and may depend on data_req_i in the same cycle.
- Handshake: a transfer occurs on a clock edge where req && gnt. Address, we, be and wdata are sampled on that edge only.
- Hit: word index = (addr - BASE_ADDR) >> 2, valid when BASE_ADDR <= addr < BASE_ADDR+SIZE_BYTES. Compare in 33-bit arithmetic so there is no wrap at 0xFFFF_FFFF.
- Write hit: bytes with be[n]=1 are updated at the grant edge. be=0 is a legal no-op that still gets a normal response. Response rdata=0, err=0.
- Read hit: the word is read at the grant edge into a hold register and presented with rvalid. A read granted the cycle after a write to the same word returns the new data.
- Miss: no SRAM access. Response err=1, rdata=0.
- FSM states:
  - IDLE: on grant, go to WAIT with counter=LATENCY-1 if LATENCY>1, otherwise go to RESP.
  - WAIT: counter decrements each cycle; at 0, go to RESP.
  - RESP: rvalid=1 for exactly one cycle. On a new grant in this cycle, go to WAIT/RESP exactly as from IDLE; otherwise go to IDLE.
- Timing: for a grant edge at the end of cycle t, rvalid is high in cycle t+LATENCY. Responses are in order, with at most one outstanding.
- Throughput: LATENCY=1 gives one transfer per cycle with req held high. LATENCY=N gives one transfer every N cycles.
- Outputs are registered except gnt. When rvalid=0, rdata and err are driven 0.
- A request that is not granted (busy) must be held by the initiator. It causes no side effects.

Decomposition:
- Shared package soc_pkg holds:
  - DMEM_BASE and DMEM_SIZE constants (default parameter values)
  - typedef be_t (logic [3:0])
  - typedef word_t (logic [31:0])
  - FSM enum resp_state_e {IDLE, WAIT, RESP}
- One sub-module, sram_1rw_be: single-port synchronous array, DEPTH=SIZE_BYTES/4, per-byte write enable, registered read. It has no reset. The responder holds only the FSM, counter, decode and response registers.

Test Plan:
1. Hold rst low with req=1 and any address -> gnt=0, rvalid=0, rdata=0, err=0 throughout. Release rst -> gnt=1 in the same cycle.
2. LATENCY=1: write 0xDEADBEEF, be=4'hF, to 0x1000_0010, then a back-to-back read of the same address -> gnt on both cycles; rvalid on both following cycles; write response rdata=0; read rdata=0xDEADBEEF, err=0.
3. Word holds 0x11223344; write be=4'b0010 with wdata=0x0000AA00, then read -> rdata=0x1122AA44.
4. Read 0x1000_1000 (BASE+SIZE) and write 0x0FFF_FFFC -> both granted, err=1, rdata=0. A following read of 0x1000_0FFC is unaffected, err=0.
5. LATENCY=3, req held high for three reads -> gnt in cycles 0,3,6; rvalid in cycles 3,6,9; gnt=0 in cycles 1,2,4,5.
6. LATENCY=3: grant a write in cycle 0, assert rst in cycle 1, release in cycle 4 -> no rvalid ever appears for the write; a later read of that address returns the written data.
